dcache_sram_arbiter: RTL and testbench
======================================

Name: dcache_sram_arbiter

Overview:
- Arbitrates the shared single-port dcache SRAM bank (data, tag and valid/dirty/shared arrays) among the miss handler, the snoop controller and the core-side cache controllers.
- Sits between the requesters and the tag-compare/SRAM stage.
- Uses fixed priority for the miss handler and snoop controller, and round-robin among the core ports.
- Adds starvation aging, a multi-cycle lock for the miss handler and snoop controller, a core-port stall, and read-response routing.

Parameters:
- NR_PORTS, 6, total requesters. Port 0 is the miss handler, port 1 is the snoop controller, ports 2..NR_PORTS-1 are core ports. Legal range is 3..16.
- ADDR_WIDTH, 12, SRAM index width.
- DATA_WIDTH, 256, flattened cache-line write word (tag, data and flags).
- BE_WIDTH, 40, flattened byte-enable width.
- STARVE_LIMIT, 8, wait cycles after which a core port is starved. Legal range is 1..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_i  in  1  masks core-port requests; does not affect ports 0 and 1.
- req_i  in  NR_PORTS  per-port request.
- lock_i  in  NR_PORTS  per-port lock hold; honoured only on ports 0 and 1, ignored on core ports.
- addr_i  in  NR_PORTS*ADDR_WIDTH  per-port index.
- we_i  in  NR_PORTS  per-port write enable.
- wdata_i  in  NR_PORTS*DATA_WIDTH  per-port write data.
- be_i  in  NR_PORTS*BE_WIDTH  per-port byte enables.
- gnt_o  out  NR_PORTS  one-hot grant, combinational, same cycle as the request.
- rvalid_o  out  NR_PORTS  read data valid, exactly 1 cycle after a read grant.
- ram_req_o  out  1  SRAM request.
- ram_we_o  out  1  SRAM write enable.
- ram_addr_o  out  ADDR_WIDTH  SRAM index.
- ram_wdata_o  out  DATA_WIDTH  SRAM write data.
- ram_be_o  out  BE_WIDTH  SRAM byte enables.
- starved_o  out  NR_PORTS  debug: core port is starved. Bits 0 and 1 are tied to 0.

Behaviour:
- State:
  - rr_ptr: round-robin pointer over core ports, range 2..NR_PORTS-1.
  - wait_cnt[p]: 8-bit wait counter per core port.
  - lock_vld / lock_owner: lock state, 1 bit each.
  - rsp_vec: registered read-response vector, NR_PORTS bits.
- Reset (rst_i high, asynchronous): rr_ptr=2, all wait_cnt=0, lock_vld=0, rsp_vec=0. This gives rvalid_o=0 and starved_o=0. gnt_o and ram_* follow the combinational rules below.
- Effective core request: ereq[p] = req_i[p] & ~stall_i, for p>=2.
- Grant selection, evaluated in order; exactly one grant or none:
  1. If lock_vld and req_i[lock_owner] and lock_i[lock_owner]: grant lock_owner only. All other ports, including port 0, wait.
  2. Else if req_i[0]: grant port 0.
  3. Else if any starved core port with ereq: grant the lowest-indexed such port.
  4. Else if req_i[1]: grant port 1.
  5. Else grant the first ereq core port scanning from rr_ptr upward, wrapping from NR_PORTS-1 to 2.
- Starvation: core port p is starved when wait_cnt[p]==STARVE_LIMIT. Starved ports outrank snoop but never outrank the miss handler or an active lock.
- wait_cnt[p] update, per cycle:
  - cleared when p is granted or req_i[p]=0;
  - otherwise, if ereq[p] & ~gnt[p], incremented, saturating at STARVE_LIMIT;
  - held while stall_i=1 with req_i[p]=1.
- rr_ptr update: on any core-port grant g (rule 3 or 5), rr_ptr = g+1, wrapping to 2. Unchanged on grants to port 0 or 1.
- Lock:
  - Set: on a grant to p in {0,1} with lock_i[p]=1, lock_vld=1 and lock_owner=p.
  - Clear: when lock_vld and ~(req_i[lock_owner] & lock_i[lock_owner]). The cycle that releases is arbitrated normally (rules 2-5), with no idle cycle.
  - Re-lock: if the same port releases and re-requests with lock in one cycle, the rules above apply unchanged.
- Datapath mux:
  - ram_req_o = |gnt_o.
  - ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o are the granted port's fields.
  - With no grant, all ram_* outputs are 0.
- Read responses: rsp_vec <= gnt_o & ~we_i; rvalid_o = rsp_vec. Writes produce no rvalid_o.
- Requester contract: a requester holds req_i and its operands stable until granted. The arbiter keeps no request queue.
- Reset asserted mid-lock clears the lock and rsp_vec immediately. rvalid_o for an in-flight read is dropped.

Test Plan:
- All NR_PORTS=6 ports request reads; lock_i=0, stall_i=0 -> gnt_o=000001 in cycle 0. rvalid_o=000001 in cycle 1; ram_addr_o equals addr_i of port 0.
- Ports 2,3,4,5 request continuously, no other requesters -> grant order 2,3,4,5,2; rr_ptr wraps 5->2.
- Port 0 grants with lock_i=1 for 4 cycles while port 1 and port 3 request -> gnt_o=000001 for 4 cycles. In cycle 5, with lock_i[0]=0 and req_i[0]=0, gnt_o=000010.
- STARVE_LIMIT=3; port 1 requests every cycle and port 4 requests -> port 4 is granted in cycle 3 ahead of snoop, and starved_o[4]=1 in that cycle.
- stall_i=1 with ports 2 and 3 requesting for 10 cycles -> gnt_o=0 and ram_req_o=0 throughout; wait_cnt stays 0. Ports 0 and 1 are still granted when they request.
- Port 2 writes (we_i=1, be_i all ones) -> ram_we_o=1 and ram_be_o all ones in the grant cycle; rvalid_o stays 0 in the next cycle. rst_i pulsed during a port-1 lock -> lock cleared and port 0 granted in the first post-reset cycle.

Source files
------------

// File: rtl/dcache_sram_arbiter_if.sv
// Request/grant and SRAM-side bundle for the dcache SRAM bank arbiter.
//   slave  : arbiter view. It takes the per-port requests and drives the grants,
//            the read responses, the debug starvation flags and the SRAM command.
//   master : requester/SRAM-stage view, which is the mirror of slave.
// Per-port fields are flattened, with port p at [p*W +: W].
interface dcache_sram_arbiter_if #(
  parameter int unsigned NR_PORTS   = 6,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned BE_WIDTH   = 40
);
  logic                           stall_i;
  logic [NR_PORTS-1:0]            req_i;
  logic [NR_PORTS-1:0]            lock_i;
  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NR_PORTS-1:0]            we_i;
  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NR_PORTS*BE_WIDTH-1:0]   be_i;
  logic [NR_PORTS-1:0]            gnt_o;
  logic [NR_PORTS-1:0]            rvalid_o;
  logic                           ram_req_o;
  logic                           ram_we_o;
  logic [ADDR_WIDTH-1:0]          ram_addr_o;
  logic [DATA_WIDTH-1:0]          ram_wdata_o;
  logic [BE_WIDTH-1:0]            ram_be_o;
  logic [NR_PORTS-1:0]            starved_o;

  modport slave (
    input  stall_i, req_i, lock_i, addr_i, we_i, wdata_i, be_i,
    output gnt_o, rvalid_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o,
           ram_be_o, starved_o
  );

  modport master (
    output stall_i, req_i, lock_i, addr_i, we_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o,
           ram_be_o, starved_o
  );
endinterface

// File: rtl/dcache_sram_arbiter.sv
// Arbiter for the shared single-port dcache SRAM bank.
// Port 0 is the miss handler and port 1 is the snoop controller. Both use fixed
// priority and can hold a multi-cycle lock. Ports 2..NR_PORTS-1 are core ports.
// They use round-robin with starvation aging, and stall_i masks them.
//   clk_i, rst_i : clock, and asynchronous active-high reset
//   bus          : dcache_sram_arbiter_if.slave. It carries the requests, the
//                  one-hot combinational grant, rvalid (one cycle after a read
//                  grant), the debug starved flags and the muxed SRAM command.
module dcache_sram_arbiter #(
  parameter int unsigned NR_PORTS     = 6,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned BE_WIDTH     = 40,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_sram_arbiter_if.slave  bus
);

  localparam int unsigned NCORE = NR_PORTS - 2;
  localparam int unsigned PTR_W = $clog2(NR_PORTS);
  localparam int unsigned CNT_W = 8;

  logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]    wait_cnt     [NR_PORTS];
  logic [CNT_W-1:0]    wait_cnt_nxt [NR_PORTS];
  logic                lock_vld, lock_vld_nxt;
  logic                lock_owner, lock_owner_nxt;
  logic                lock_hold;
  logic [NR_PORTS-1:0] rsp_vec;
  logic [NR_PORTS-1:0] gnt, ereq, starved;
  logic                found;

  logic                  mux_we;
  logic [ADDR_WIDTH-1:0] mux_addr;
  logic [DATA_WIDTH-1:0] mux_wdata;
  logic [BE_WIDTH-1:0]   mux_be;

  // Wrap a core-port index that ran past the top back to port 2.
  function automatic int unsigned wrap_idx(input int unsigned i);
    return (i >= NR_PORTS) ? i - NCORE : i;
  endfunction

  // Effective core requests (stall-masked) and the starvation flags.
  always_comb begin
    ereq    = '0;
    starved = '0;
    for (int unsigned p = 2; p < NR_PORTS; p++) begin
      ereq[p]    = bus.req_i[p] & ~bus.stall_i;
      starved[p] = (wait_cnt[p] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Grant selection: lock, then miss handler, then starved core, then snoop, then round-robin.
  always_comb begin
    gnt       = '0;
    found     = 1'b0;
    lock_hold = lock_vld & bus.req_i[PTR_W'(lock_owner)] & bus.lock_i[PTR_W'(lock_owner)];
    if (lock_hold) begin
      gnt[PTR_W'(lock_owner)] = 1'b1;
    end else if (bus.req_i[0]) begin
      gnt[0] = 1'b1;
    end else if (|(starved & ereq)) begin
      for (int unsigned p = 2; p < NR_PORTS; p++) begin
        if (!found && starved[p] && ereq[p]) begin
          gnt[p] = 1'b1;
          found  = 1'b1;
        end
      end
    end else if (bus.req_i[1]) begin
      gnt[1] = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NCORE; k++) begin
        if (!found && ereq[PTR_W'(wrap_idx(32'(rr_ptr) + k))]) begin
          gnt[PTR_W'(wrap_idx(32'(rr_ptr) + k))] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  // Next-state: round-robin pointer, wait counters, lock.
  always_comb begin
    rr_ptr_nxt     = rr_ptr;
    lock_vld_nxt   = 1'b0;
    lock_owner_nxt = lock_owner;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      wait_cnt_nxt[p] = '0;
    end
    for (int unsigned p = 2; p < NR_PORTS; p++) begin
      if (gnt[p]) begin
        rr_ptr_nxt = PTR_W'(wrap_idx(p + 1));
      end
      // A stalled but still-requesting port keeps its age unchanged.
      if (gnt[p] || !bus.req_i[p]) begin
        wait_cnt_nxt[p] = '0;
      end else if (ereq[p]) begin
        wait_cnt_nxt[p] = (wait_cnt[p] < CNT_W'(STARVE_LIMIT)) ? wait_cnt[p] + CNT_W'(1)
                                                               : wait_cnt[p];
      end else begin
        wait_cnt_nxt[p] = wait_cnt[p];
      end
    end
    if (lock_hold) begin
      lock_vld_nxt = 1'b1;
    end else if (gnt[0] && bus.lock_i[0]) begin
      lock_vld_nxt   = 1'b1;
      lock_owner_nxt = 1'b0;
    end else if (gnt[1] && bus.lock_i[1]) begin
      lock_vld_nxt   = 1'b1;
      lock_owner_nxt = 1'b1;
    end
  end

  // SRAM command mux. The grant is one-hot, so an OR across ports is enough.
  always_comb begin
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    mux_be    = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      if (gnt[p]) begin
        mux_we    = mux_we    | bus.we_i[p];
        mux_addr  = mux_addr  | bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        mux_wdata = mux_wdata | bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        mux_be    = mux_be    | bus.be_i[p*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= PTR_W'(2);
      lock_vld   <= 1'b0;
      lock_owner <= 1'b0;
      rsp_vec    <= '0;
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        wait_cnt[p] <= '0;
      end
    end else begin
      rr_ptr     <= rr_ptr_nxt;
      lock_vld   <= lock_vld_nxt;
      lock_owner <= lock_owner_nxt;
      rsp_vec    <= gnt & ~bus.we_i;
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        wait_cnt[p] <= wait_cnt_nxt[p];
      end
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rsp_vec;
  assign bus.starved_o   = starved;
  assign bus.ram_req_o   = |gnt;
  assign bus.ram_we_o    = mux_we;
  assign bus.ram_addr_o  = mux_addr;
  assign bus.ram_wdata_o = mux_wdata;
  assign bus.ram_be_o    = mux_be;

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Directed bench for dcache_sram_arbiter.
// Two instances share one stimulus. u_dut uses the default STARVE_LIMIT=8.
// u_dut_s3 uses STARVE_LIMIT=3 and is checked only in the starvation and stall cases.
module tb_dcache_sram_arbiter;
  localparam int unsigned NP = 6;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 256;
  localparam int unsigned BW = 40;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dcache_sram_arbiter_if #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) if0 ();
  dcache_sram_arbiter_if #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) if1 ();

  assign if1.stall_i = if0.stall_i;
  assign if1.req_i   = if0.req_i;
  assign if1.lock_i  = if0.lock_i;
  assign if1.addr_i  = if0.addr_i;
  assign if1.we_i    = if0.we_i;
  assign if1.wdata_i = if0.wdata_i;
  assign if1.be_i    = if0.be_i;

  dcache_sram_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
                        .STARVE_LIMIT(8)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if0.slave)
  );

  dcache_sram_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
                        .STARVE_LIMIT(3)) u_dut_s3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1.slave)
  );

  typedef struct {
    logic          stall;
    logic [NP-1:0] req;
    logic [NP-1:0] lock;
    logic [NP-1:0] we;
    logic [NP-1:0] exp_gnt;
    logic [NP-1:0] exp_rvalid;
  } vec_t;

  vec_t vt [15];

  function automatic logic [AW-1:0] addr_of(input int p);
    return AW'(32'h100 + p);
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int p);
    return {8{32'(32'hA5A5_0000 + p)}};
  endfunction

  function automatic logic [BW-1:0] be_of(input int p);
    logic [BW-1:0] v;
    v = (p == 2) ? {BW{1'b1}} : {5{8'(8'h10 + p)}};
    return v;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic [NP-1:0] req, input logic [NP-1:0] lock,
                       input logic [NP-1:0] we);
    if0.stall_i = stall;
    if0.req_i   = req;
    if0.lock_i  = lock;
    if0.we_i    = we;
  endtask

  // One cycle on u_dut: apply the inputs, check at the negedge, then advance to just after the posedge.
  task automatic step(input string nm, input logic stall, input logic [NP-1:0] req,
                      input logic [NP-1:0] lock, input logic [NP-1:0] we,
                      input logic [NP-1:0] exp_gnt, input logic [NP-1:0] exp_rvalid);
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] eb;
    ew = 1'b0;
    ea = '0;
    ed = '0;
    eb = '0;
    for (int p = 0; p < int'(NP); p++) begin
      if (exp_gnt[p]) begin
        ew = we[p];
        ea = addr_of(p);
        ed = wdata_of(p);
        eb = be_of(p);
      end
    end
    drive(stall, req, lock, we);
    @(negedge clk);
    check({nm, ".gnt"},     DW'(if0.gnt_o),     DW'(exp_gnt));
    check({nm, ".rvalid"},  DW'(if0.rvalid_o),  DW'(exp_rvalid));
    check({nm, ".ram_req"}, DW'(if0.ram_req_o), DW'(|exp_gnt));
    check({nm, ".ram_we"},  DW'(if0.ram_we_o),  DW'(ew));
    check({nm, ".addr"},    DW'(if0.ram_addr_o), DW'(ea));
    check({nm, ".wdata"},   if0.ram_wdata_o,    ed);
    check({nm, ".be"},      DW'(if0.ram_be_o),  DW'(eb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stall, req, lock, we, exp_gnt, exp_rvalid
    vt[0]  = '{1'b0, 6'b000000, 6'b0, 6'b0,      6'b000000, 6'b000000};
    vt[1]  = '{1'b0, 6'b111111, 6'b0, 6'b0,      6'b000001, 6'b000000};
    vt[2]  = '{1'b0, 6'b000000, 6'b0, 6'b0,      6'b000000, 6'b000001};
    vt[3]  = '{1'b0, 6'b111100, 6'b0, 6'b0,      6'b000100, 6'b000000};
    vt[4]  = '{1'b0, 6'b111100, 6'b0, 6'b0,      6'b001000, 6'b000100};
    vt[5]  = '{1'b0, 6'b111100, 6'b0, 6'b0,      6'b010000, 6'b001000};
    vt[6]  = '{1'b0, 6'b111100, 6'b0, 6'b0,      6'b100000, 6'b010000};
    vt[7]  = '{1'b0, 6'b111100, 6'b0, 6'b0,      6'b000100, 6'b100000};
    vt[8]  = '{1'b0, 6'b000000, 6'b0, 6'b0,      6'b000000, 6'b000100};
    vt[9]  = '{1'b1, 6'b001100, 6'b0, 6'b0,      6'b000000, 6'b000000};
    vt[10] = '{1'b1, 6'b001110, 6'b0, 6'b0,      6'b000010, 6'b000000};
    vt[11] = '{1'b1, 6'b001101, 6'b0, 6'b0,      6'b000001, 6'b000010};
    vt[12] = '{1'b0, 6'b001100, 6'b0, 6'b0,      6'b001000, 6'b000001};
    vt[13] = '{1'b0, 6'b000100, 6'b0, 6'b000100, 6'b000100, 6'b001000};
    vt[14] = '{1'b0, 6'b000000, 6'b0, 6'b0,      6'b000000, 6'b000000};

    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    for (int p = 0; p < int'(NP); p++) begin
      if0.addr_i[p*AW +: AW]  = addr_of(p);
      if0.wdata_i[p*DW +: DW] = wdata_of(p);
      if0.be_i[p*BW +: BW]    = be_of(p);
    end

    // Reset state
    @(negedge clk);
    check("rst.gnt",     DW'(if0.gnt_o),     DW'(0));
    check("rst.rvalid",  DW'(if0.rvalid_o),  DW'(0));
    check("rst.starved", DW'(if0.starved_o), DW'(0));
    check("rst.ram_req", DW'(if0.ram_req_o), DW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: priority, round-robin wrap, stall masking, write without rvalid
    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vt[i].stall, vt[i].req, vt[i].lock, vt[i].we,
           vt[i].exp_gnt, vt[i].exp_rvalid);
    end

    // Miss-handler lock held 4 cycles over snoop and core port 3, then release to snoop
    step("lk0_c1", 1'b0, 6'b001011, 6'b000001, 6'b0, 6'b000001, 6'b000000);
    step("lk0_c2", 1'b0, 6'b001011, 6'b000001, 6'b0, 6'b000001, 6'b000001);
    step("lk0_c3", 1'b0, 6'b001011, 6'b000001, 6'b0, 6'b000001, 6'b000001);
    step("lk0_c4", 1'b0, 6'b001011, 6'b000001, 6'b0, 6'b000001, 6'b000001);
    step("lk0_rel", 1'b0, 6'b001010, 6'b000000, 6'b0, 6'b000010, 6'b000001);
    step("lk0_core", 1'b0, 6'b001000, 6'b000000, 6'b0, 6'b001000, 6'b000010);

    // Snoop lock outranks the miss handler, then an async reset drops the lock and rvalid
    step("lk1_c1", 1'b0, 6'b000010, 6'b000010, 6'b0, 6'b000010, 6'b001000);
    step("lk1_c2", 1'b0, 6'b000011, 6'b000010, 6'b0, 6'b000010, 6'b000010);
    check("lk1.rvalid_pre", DW'(if0.rvalid_o), DW'(6'b000010));
    rst = 1'b1;
    #1;
    check("rstmid.rvalid", DW'(if0.rvalid_o), DW'(0));
    check("rstmid.gnt",    DW'(if0.gnt_o),    DW'(6'b000001));
    #1;
    rst = 1'b0;
    step("post_rst", 1'b0, 6'b000011, 6'b000010, 6'b0, 6'b000001, 6'b000000);

    // Fresh reset, then starvation (u_dut_s3): port 4 ages past the snoop controller
    drive(1'b0, '0, '0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 6'b010010, '0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stv_c%0d.gnt", c),     DW'(if1.gnt_o),     DW'(6'b000010));
      check($sformatf("stv_c%0d.starved", c), DW'(if1.starved_o), DW'(0));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("stv_c3.gnt",      DW'(if1.gnt_o),      DW'(6'b010000));
    check("stv_c3.starved",  DW'(if1.starved_o),  DW'(6'b010000));
    check("stv_c3.addr",     DW'(if1.ram_addr_o), DW'(addr_of(4)));
    check("stv_c3.lim8_gnt", DW'(if0.gnt_o),      DW'(6'b000010));
    @(posedge clk);
    #1;

    // Stall for 10 cycles: no core grant, and wait counters must not age
    drive(1'b1, 6'b001100, '0, '0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d.gnt", c), DW'(if1.gnt_o),     DW'(0));
      check($sformatf("stall_c%0d.req", c), DW'(if1.ram_req_o), DW'(0));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("stall.starved", DW'(if1.starved_o), DW'(0));
    @(posedge clk);
    #1;
    drive(1'b0, 6'b001100, '0, '0);
    @(negedge clk);
    check("unstall.gnt", DW'(if1.gnt_o), DW'(6'b000100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
